pllctrl: RTL and testbench

Memory-mapped PLL configuration sequencer. It lives in the uncore as an AHB-Lite peripheral beside the CLINT, PLIC, GPIO, UART and SPI blocks, and drives the SoC-level PLL configuration pins (PLLclkr, PLLclkf, PLLclkod, PLLbwadj, PLLbypass, PLLtest). Software writes shadow divider settings and then sets GO. The block bypasses the PLL, applies the new settings, waits a settle interval and a stable lock, then releases bypass or flags a timeout.

---
 rtl/pllctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_pllctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pllctrl.sv
// AHB-Lite PLL configuration sequencer: bypass, load dividers, settle, wait for stable lock, release.
// Optional lock-loss monitor in IDLE is built when PLLCTRL_LOCKMON_EN is defined.
module pllctrl #(
  parameter int LOCKSTABLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSELPLL,
  input  logic [7:0]  HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HREADPLL,
  output logic        HRESPPLL,
  output logic        HREADYPLL,
  input  logic        PLLlock,
  output logic [5:0]  PLLclkr,
  output logic [12:0] PLLclkf,
  output logic [3:0]  PLLclkod,
  output logic [11:0] PLLbwadj,
  output logic        PLLbypass,
  output logic        PLLtest,
  output logic        PLLIntr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BYP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAITLK = 3'd4;
  localparam logic [2:0] S_REL    = 3'd5;

  localparam int SW = $clog2(LOCKSTABLE + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCKSTABLE);

  logic          lock_meta, lock_sync;
  logic          dph_wr;
  logic [2:0]    dph_addr;
  logic [5:0]    cfg_clkr;
  logic [3:0]    cfg_clkod;
  logic [12:0]   cfg_clkf;
  logic [11:0]   cfg_bwadj;
  logic          cfg_test;
  logic          force_bypass, ie;
  logic          done, timeout, lostlock;
  logic [15:0]   settle_cyc;
  logic [23:0]   tmo_cyc;
  logic [2:0]    state;
  logic [23:0]   cnt;
  logic [SW-1:0] stable;
  logic          go_pend, seq_ok;

  logic          accept, busy, protect;
  logic          wr_cfg0, wr_cfg1, wr_ctrl, wr_stat, wr_settle, wr_tmo, go_req, go_start;
  logic          set_done, set_tmo, lost_evt;
  logic          done_nxt, tmo_nxt, lost_nxt, ie_nxt;
  logic [31:0]   rd_data;
  logic          unused;

  assign HRESPPLL  = 1'b0;
  assign HREADYPLL = 1'b1;
  assign unused    = ^{HWDATA[31:29], HADDR[7:5], HADDR[1:0], HTRANS[0]};

`ifdef PLLCTRL_LOCKMON_EN
  logic lock_prev;

  // previous synchronized lock, for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) lock_prev <= 1'b0;
    else       lock_prev <= lock_sync;
  end

  assign lost_evt = (state == S_IDLE) & seq_ok & lock_prev & ~lock_sync;
`else
  assign lost_evt = 1'b0;
`endif

  always_comb begin
    accept    = HSELPLL & HTRANS[1] & HREADY;
    busy      = (state != S_IDLE);
    // a pending GO already owns the shadows, so protect them a cycle early
    protect   = busy | go_pend;
    wr_cfg0   = dph_wr & (dph_addr == 3'd0) & ~protect;
    wr_cfg1   = dph_wr & (dph_addr == 3'd1) & ~protect;
    wr_ctrl   = dph_wr & (dph_addr == 3'd2);
    wr_stat   = dph_wr & (dph_addr == 3'd3);
    wr_settle = dph_wr & (dph_addr == 3'd4) & ~protect;
    wr_tmo    = dph_wr & (dph_addr == 3'd5) & ~protect;
    go_req    = wr_ctrl & HWDATA[0] & ~protect;
    go_start  = (state == S_IDLE) & go_pend;
    set_done  = (state == S_REL);
    set_tmo   = (state == S_WAITLK) & (stable != STABLE_MAX) & (cnt == 24'd0);

    if (set_done) done_nxt = 1'b1;
    else if (go_start | (wr_stat & HWDATA[2])) done_nxt = 1'b0;
    else done_nxt = done;

    if (set_tmo) tmo_nxt = 1'b1;
    else if (go_start | (wr_stat & HWDATA[3])) tmo_nxt = 1'b0;
    else tmo_nxt = timeout;

    if (lost_evt) lost_nxt = 1'b1;
    else if (wr_stat & HWDATA[7]) lost_nxt = 1'b0;
    else lost_nxt = lostlock;

    ie_nxt = wr_ctrl ? HWDATA[2] : ie;

    case (HADDR[4:2])
      3'd0:    rd_data = {3'b0, cfg_clkf, 4'b0, cfg_clkod, 2'b0, cfg_clkr};
      3'd1:    rd_data = {15'b0, cfg_test, 4'b0, cfg_bwadj};
      3'd2:    rd_data = {29'b0, ie, force_bypass, 1'b0};
      3'd3:    rd_data = {24'b0, lostlock, state, timeout, done, lock_sync, busy};
      3'd4:    rd_data = {16'b0, settle_cyc};
      3'd5:    rd_data = {8'b0, tmo_cyc};
      default: rd_data = 32'h0;
    endcase
  end

  // lock synchronizer, bus phase capture and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      dph_wr    <= 1'b0;
      dph_addr  <= 3'd0;
      HREADPLL  <= 32'h0;
    end else begin
      lock_meta <= PLLlock;
      lock_sync <= lock_meta;
      dph_wr    <= accept & HWRITE;
      dph_addr  <= HADDR[4:2];
      HREADPLL  <= (accept & ~HWRITE) ? rd_data : 32'h0;
    end
  end

  // software-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_clkr     <= 6'd0;
      cfg_clkod    <= 4'd0;
      cfg_clkf     <= 13'd0;
      cfg_bwadj    <= 12'd0;
      cfg_test     <= 1'b0;
      force_bypass <= 1'b0;
      ie           <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      lostlock     <= 1'b0;
      settle_cyc   <= 16'h0100;
      tmo_cyc      <= 24'h0F_FFFF;
      go_pend      <= 1'b0;
      PLLIntr      <= 1'b0;
    end else begin
      if (wr_cfg0) begin
        cfg_clkr  <= HWDATA[5:0];
        cfg_clkod <= HWDATA[11:8];
        cfg_clkf  <= HWDATA[28:16];
      end
      if (wr_cfg1) begin
        cfg_bwadj <= HWDATA[11:0];
        cfg_test  <= HWDATA[16];
      end
      if (wr_ctrl) force_bypass <= HWDATA[1];
      if (wr_settle) settle_cyc <= HWDATA[15:0];
      if (wr_tmo) tmo_cyc <= HWDATA[23:0];
      ie       <= ie_nxt;
      done     <= done_nxt;
      timeout  <= tmo_nxt;
      lostlock <= lost_nxt;
      go_pend  <= go_req;
      PLLIntr  <= ie_nxt & (done_nxt | tmo_nxt | lost_nxt);
    end
  end

  // sequencer FSM, counters and PLL pins
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 24'd0;
      stable    <= '0;
      seq_ok    <= 1'b0;
      PLLbypass <= 1'b1;
      PLLclkr   <= 6'd0;
      PLLclkf   <= 13'd0;
      PLLclkod  <= 4'd0;
      PLLbwadj  <= 12'd0;
      PLLtest   <= 1'b0;
    end else begin
      if ((state == S_WAITLK) && lock_sync)
        stable <= (stable == STABLE_MAX) ? stable : stable + 1'b1;
      else
        stable <= '0;

      case (state)
        S_IDLE: begin
          if (go_pend) begin
            state     <= S_BYP;
            seq_ok    <= 1'b0;
            PLLbypass <= 1'b1;
          end else if (lost_evt) begin
            seq_ok    <= 1'b0;
            PLLbypass <= 1'b1;
          end else begin
            PLLbypass <= seq_ok ? force_bypass : 1'b1;
          end
        end
        S_BYP: begin
          PLLbypass <= 1'b1;
          PLLclkr   <= cfg_clkr;
          PLLclkf   <= cfg_clkf;
          PLLclkod  <= cfg_clkod;
          PLLbwadj  <= cfg_bwadj;
          PLLtest   <= cfg_test;
          state     <= S_LOAD;
        end
        S_LOAD: begin
          cnt   <= {8'd0, settle_cyc};
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == 24'd0) begin
            cnt   <= tmo_cyc;
            state <= S_WAITLK;
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        S_WAITLK: begin
          // stable lock wins over a simultaneous timeout
          if (stable == STABLE_MAX) state <= S_REL;
          else if (cnt == 24'd0) state <= S_IDLE;
          else cnt <= cnt - 24'd1;
        end
        S_REL: begin
          PLLbypass <= force_bypass;
          seq_ok    <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          PLLbypass <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pllctrl.sv
// Self-checking bench for pllctrl: register table plus sequence, timeout, glitch, protect and reset scenarios.
module tb_pllctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        HSELPLL, HWRITE, HREADY;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HREADPLL;
  logic        HRESPPLL, HREADYPLL, PLLlock;
  logic [5:0]  PLLclkr;
  logic [12:0] PLLclkf;
  logic [3:0]  PLLclkod;
  logic [11:0] PLLbwadj;
  logic        PLLbypass, PLLtest, PLLIntr;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[24];
  int   ntbl;

  always #5 clk = ~clk;

  pllctrl #(.LOCKSTABLE(4)) dut (
    .clk(clk), .reset(reset), .HSELPLL(HSELPLL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA), .HREADPLL(HREADPLL),
    .HRESPPLL(HRESPPLL), .HREADYPLL(HREADYPLL), .PLLlock(PLLlock),
    .PLLclkr(PLLclkr), .PLLclkf(PLLclkf), .PLLclkod(PLLclkod), .PLLbwadj(PLLbwadj),
    .PLLbypass(PLLbypass), .PLLtest(PLLtest), .PLLIntr(PLLIntr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    HSELPLL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge clk); #1;
    HSELPLL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    HSELPLL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge clk); #1;
    HSELPLL = 1'b0; HTRANS = 2'b00;
    e = exp_q.pop_front();
    check(name, HREADPLL, e);
  endtask

  task automatic check_pll(input string tag, input logic [5:0] r, input logic [12:0] f,
                           input logic [3:0] od, input logic byp);
    check({tag, "_clkr"}, {26'd0, PLLclkr}, {26'd0, r});
    check({tag, "_clkf"}, {19'd0, PLLclkf}, {19'd0, f});
    check({tag, "_clkod"}, {28'd0, PLLclkod}, {28'd0, od});
    check({tag, "_bypass"}, {31'd0, PLLbypass}, {31'd0, byp});
  endtask

  initial begin
    reset = 1'b1; HSELPLL = 1'b0; HWRITE = 1'b0; HREADY = 1'b1; HADDR = 8'h0;
    HTRANS = 2'b00; HWDATA = 32'h0; PLLlock = 1'b0;
    edges(2);
    reset = 1'b0;
    edges(1);

    // reset state
    check_pll("rst", 6'd0, 13'd0, 4'd0, 1'b1);
    check("rst_bwadj", {20'd0, PLLbwadj}, 32'd0);
    check("rst_test", {31'd0, PLLtest}, 32'd0);
    check("rst_intr", {31'd0, PLLIntr}, 32'd0);
    check("rst_hresp_hready", {30'd0, HRESPPLL, HREADYPLL}, 32'd1);
    check("rst_hread", HREADPLL, 32'd0);

    // register access table
    ntbl = 0;
    tbl[ntbl++] = '{1'b0, 8'h0C, 32'h0, 32'h0000_0000};
    tbl[ntbl++] = '{1'b0, 8'h10, 32'h0, 32'h0000_0100};
    tbl[ntbl++] = '{1'b0, 8'h14, 32'h0, 32'h000F_FFFF};
    tbl[ntbl++] = '{1'b0, 8'h00, 32'h0, 32'h0000_0000};
    tbl[ntbl++] = '{1'b0, 8'h08, 32'h0, 32'h0000_0000};
    tbl[ntbl++] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h00, 32'h0, 32'h1FFF_0F3F};
    tbl[ntbl++] = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h04, 32'h0, 32'h0001_0FFF};
    tbl[ntbl++] = '{1'b1, 8'h18, 32'h1234_5678, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h18, 32'h0, 32'h0000_0000};
    tbl[ntbl++] = '{1'b0, 8'h1C, 32'h0, 32'h0000_0000};
    tbl[ntbl++] = '{1'b1, 8'h08, 32'h0000_0006, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h08, 32'h0, 32'h0000_0006};
    tbl[ntbl++] = '{1'b1, 8'h08, 32'h0000_0000, 32'h0};
    tbl[ntbl++] = '{1'b1, 8'h10, 32'hABCD_1234, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h10, 32'h0, 32'h0000_1234};
    tbl[ntbl++] = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h14, 32'h0, 32'h00FF_FFFF};
    tbl[ntbl++] = '{1'b1, 8'h00, 32'h0031_0201, 32'h0};
    tbl[ntbl++] = '{1'b0, 8'h00, 32'h0, 32'h0031_0201};
    tbl[ntbl++] = '{1'b1, 8'h04, 32'h0000_0000, 32'h0};
    tbl[ntbl++] = '{1'b1, 8'h10, 32'h0000_0008, 32'h0};
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      else bus_read($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end
    // shadows alone never reach the pins; bypass stays on before any success
    check_pll("idle_shadow", 6'd0, 13'd0, 4'd0, 1'b1);

    // normal sequence, lock already high
    PLLlock = 1'b1;
    edges(3);
    bus_write(8'h08, 32'h5);           // edge N
    edges(1);
    check("seq_bypass_n1", {31'd0, PLLbypass}, 32'd1);
    edges(1);
    check_pll("seq_n2", 6'd1, 13'h031, 4'd2, 1'b1);
    edges(15);
    check("seq_intr_n17", {31'd0, PLLIntr}, 32'd0);
    check("seq_bypass_n17", {31'd0, PLLbypass}, 32'd1);
    edges(1);
    check("seq_intr_n18", {31'd0, PLLIntr}, 32'd1);
    check("seq_bypass_n18", {31'd0, PLLbypass}, 32'd0);
    bus_read("seq_status", 8'h0C, 32'h06);
    bus_read("seq_ctrl", 8'h08, 32'h04);

    // timeout
    PLLlock = 1'b0;
    edges(3);
    bus_write(8'h14, 32'd20);
    bus_write(8'h08, 32'h5);           // edge N
    edges(1);
    check("tmo_intr_n1", {31'd0, PLLIntr}, 32'd0);
    check("tmo_bypass_n1", {31'd0, PLLbypass}, 32'd1);
    edges(31);
    check("tmo_intr_n32", {31'd0, PLLIntr}, 32'd0);
    edges(1);
    check("tmo_intr_n33", {31'd0, PLLIntr}, 32'd1);
    check("tmo_bypass_n33", {31'd0, PLLbypass}, 32'd1);
    bus_read("tmo_status", 8'h0C, 32'h08);
    bus_write(8'h0C, 32'h08);
    check("tmo_w1c_intr", {31'd0, PLLIntr}, 32'd0);
    bus_read("tmo_w1c_status", 8'h0C, 32'h00);
    check("tmo_idle_bypass", {31'd0, PLLbypass}, 32'd1);

    // lock glitch restarts the stable count
    bus_write(8'h10, 32'd2);
    bus_write(8'h14, 32'd100);
    bus_write(8'h08, 32'h5);           // edge N, WAITLK from N+6
    edges(8);
    PLLlock = 1'b1;
    edges(3);
    PLLlock = 1'b0;
    edges(1);
    PLLlock = 1'b1;                    // final rise after N+12
    edges(7);
    check("glitch_intr_n19", {31'd0, PLLIntr}, 32'd0);
    edges(1);
    check("glitch_intr_n20", {31'd0, PLLIntr}, 32'd1);
    check("glitch_bypass_n20", {31'd0, PLLbypass}, 32'd0);

    // busy write protect
    bus_write(8'h10, 32'd30);
    bus_write(8'h14, 32'h000F_FFFF);
    bus_write(8'h08, 32'h5);           // edge N
    bus_write(8'h00, 32'hFFFF_FFFF);
    bus_write(8'h08, 32'h5);
    bus_write(8'h10, 32'h3);
    bus_read("busy_status", 8'h0C, 32'h33);
    bus_read("busy_cfg0", 8'h00, 32'h0031_0201);
    bus_read("busy_settle", 8'h10, 32'd30);
    check_pll("busy_pins", 6'd1, 13'h031, 4'd2, 1'b1);
    edges(30);
    check("busy_intr_n39", {31'd0, PLLIntr}, 32'd0);
    edges(1);
    check("busy_intr_n40", {31'd0, PLLIntr}, 32'd1);
    edges(4);
    bus_read("busy_second_go", 8'h0C, 32'h06);

    // lock loss after a successful sequence
    PLLlock = 1'b0;
    edges(3);
`ifdef PLLCTRL_LOCKMON_EN
    check("lockmon_bypass", {31'd0, PLLbypass}, 32'd1);
    bus_read("lockmon_status", 8'h0C, 32'h84);
    bus_write(8'h0C, 32'h80);
    bus_read("lockmon_w1c", 8'h0C, 32'h04);
`else
    check("nolockmon_bypass", {31'd0, PLLbypass}, 32'd0);
    bus_write(8'h0C, 32'h80);
    bus_read("nolockmon_status", 8'h0C, 32'h04);
`endif

    // reset in the middle of a sequence
    PLLlock = 1'b1;
    bus_write(8'h08, 32'h5);
    edges(5);
    reset = 1'b1;
    edges(2);
    reset = 1'b0;
    check_pll("midrst", 6'd0, 13'd0, 4'd0, 1'b1);
    check("midrst_intr", {31'd0, PLLIntr}, 32'd0);
    edges(3);
    bus_read("midrst_status", 8'h0C, 32'h02);
    bus_read("midrst_settle", 8'h10, 32'h100);
    bus_read("midrst_ctrl", 8'h08, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
